// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer with frame-alignment FSM, sync-error flag and good-frame counter.
// Define TDM_DEMUX_SHADOW_EN to stage slots 0..2 and publish whole frames only.
module tdm_demux4 #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [DATA_W-1:0] O0,
   output logic [DATA_W-1:0] O1,
   output logic [DATA_W-1:0] O2,
   output logic [DATA_W-1:0] O3,
   output logic              frame_valid,
   output logic              sync_err,
   output logic              locked,
   output logic [1:0]        slot,
   output logic [CNT_W-1:0]  frame_cnt
);

   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

   state_t             state_reg, state_next;
   logic [1:0]         slot_reg, slot_next;
   logic               frame_valid_reg, frame_valid_next;
   logic               sync_err_reg, sync_err_next;
   logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
   logic [3:0]         slot_wr;
   logic [3:0]         ch_load;
   logic [DATA_W-1:0]  ch_next [4];
   logic [DATA_W-1:0]  ch_reg  [4];

   // Alignment FSM: decides which slot (if any) the accepted sample fills.
   always_comb begin
      state_next       = state_reg;
      slot_next        = slot_reg;
      frame_valid_next = 1'b0;
      sync_err_next    = 1'b0;
      frame_cnt_next   = frame_cnt_reg;
      slot_wr          = 4'b0000;
      if (din_valid) begin
         case (state_reg)
            HUNT: begin
               if (frame_sync) begin
                  slot_wr[0] = 1'b1;
                  slot_next  = 2'd1;
                  state_next = RUN;
               end
            end
            RUN: begin
               if (frame_sync) begin
                  // Early sync restarts the frame at this sample.
                  sync_err_next = (slot_reg != 2'd0);
                  slot_wr[0]    = 1'b1;
                  slot_next     = 2'd1;
               end else if (slot_reg == 2'd0) begin
                  sync_err_next = 1'b1;
                  slot_next     = 2'd0;
                  state_next    = HUNT;
               end else begin
                  slot_wr[slot_reg] = 1'b1;
                  slot_next         = slot_reg + 2'd1;
                  if (slot_reg == 2'd3) begin
                     frame_valid_next = 1'b1;
                     frame_cnt_next   = frame_cnt_reg + 1'b1;
                  end
               end
            end
            default: begin
               state_next = HUNT;
               slot_next  = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= HUNT;
         slot_reg        <= 2'd0;
         frame_valid_reg <= 1'b0;
         sync_err_reg    <= 1'b0;
         frame_cnt_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         slot_reg        <= slot_next;
         frame_valid_reg <= frame_valid_next;
         sync_err_reg    <= sync_err_next;
         frame_cnt_reg   <= frame_cnt_next;
      end
   end

`ifdef TDM_DEMUX_SHADOW_EN
   logic [DATA_W-1:0] stage_reg [3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) stage_reg[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (slot_wr[i]) stage_reg[i] <= din;
      end
   end

   // All four outputs publish together when the slot-3 sample lands.
   always_comb begin
      ch_load = {4{slot_wr[3]}};
      for (int i = 0; i < 3; i++) ch_next[i] = stage_reg[i];
      ch_next[3] = din;
   end
`else
   always_comb begin
      ch_load = slot_wr;
      for (int i = 0; i < 4; i++) ch_next[i] = din;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) ch_reg[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (ch_load[i]) ch_reg[i] <= ch_next[i];
      end
   end

   assign O0          = ch_reg[0];
   assign O1          = ch_reg[1];
   assign O2          = ch_reg[2];
   assign O3          = ch_reg[3];
   assign frame_valid = frame_valid_reg;
   assign sync_err    = sync_err_reg;
   assign locked      = (state_reg == RUN);
   assign slot        = slot_reg;
   assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (counter narrowed to 4 bits to exercise wrap).
`timescale 1ns/1ps
module tb_tdm_demux4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              din_valid = 1'b0;
   logic              frame_sync = 1'b0;
   logic [DATA_W-1:0] O0, O1, O2, O3;
   logic              frame_valid, sync_err, locked;
   logic [1:0]        slot;
   logic [CNT_W-1:0]  frame_cnt;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   tdm_demux4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .frame_sync(frame_sync), .O0(O0), .O1(O1), .O2(O2), .O3(O3),
      .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked),
      .slot(slot), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
         $display("ok   %s got=0x%0h", tag, got);
      end else begin
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Present one cycle of input, then sample 1ns after the capturing edge.
   task automatic send(input logic [7:0] d, input logic fs, input logic v);
      @(negedge clk);
      din = d; frame_sync = fs; din_valid = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_O0", O0, 0);
      chk("rst_O3", O3, 0);
      chk("rst_locked", locked, 0);
      chk("rst_slot", slot, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_fv", frame_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsynced samples in HUNT are dropped
      send(8'hAA, 1'b0, 1'b1);
      send(8'hBB, 1'b0, 1'b1);
      chk("hunt_locked", locked, 0);
      chk("hunt_O0", O0, 0);
      chk("hunt_O1", O1, 0);
      chk("hunt_err", sync_err, 0);
      chk("hunt_fv", frame_valid, 0);

      // Continuous frame
      send(8'h11, 1'b1, 1'b1);
      chk("f1_locked", locked, 1);
      chk("f1_slot", slot, 1);
`ifdef TDM_DEMUX_SHADOW_EN
      chk("f1_O0_early", O0, 8'h00);
`else
      chk("f1_O0_early", O0, 8'h11);
`endif
      send(8'h22, 1'b0, 1'b1);
      send(8'h33, 1'b0, 1'b1);
      chk("f1_fv_pre", frame_valid, 0);
      send(8'h44, 1'b0, 1'b1);
      chk("f1_O0", O0, 8'h11);
      chk("f1_O1", O1, 8'h22);
      chk("f1_O2", O2, 8'h33);
      chk("f1_O3", O3, 8'h44);
      chk("f1_fv", frame_valid, 1);
      chk("f1_cnt", frame_cnt, 1);
      chk("f1_slot_wrap", slot, 0);
      send(8'h00, 1'b0, 1'b0);
      chk("f1_fv_drop", frame_valid, 0);

      // Frame with din_valid toggling
      send(8'h21, 1'b1, 1'b1);
      send(8'hEE, 1'b1, 1'b0);
      chk("tg_slot_frozen", slot, 1);
      send(8'h32, 1'b0, 1'b1);
      send(8'hEE, 1'b0, 1'b0);
      send(8'h43, 1'b0, 1'b1);
      send(8'hEE, 1'b0, 1'b0);
      chk("tg_fv_pre", frame_valid, 0);
      send(8'h54, 1'b0, 1'b1);
      chk("tg_fv", frame_valid, 1);
      chk("tg_O0", O0, 8'h21);
      chk("tg_O1", O1, 8'h32);
      chk("tg_O2", O2, 8'h43);
      chk("tg_O3", O3, 8'h54);
      chk("tg_cnt", frame_cnt, 2);
      send(8'hEE, 1'b0, 1'b0);
      chk("tg_fv_once", frame_valid, 0);

      // Early sync on slot 2
      send(8'h5A, 1'b1, 1'b1);
      send(8'h5B, 1'b0, 1'b1);
      send(8'h55, 1'b1, 1'b1);
      chk("es_err", sync_err, 1);
      chk("es_slot", slot, 1);
      chk("es_cnt", frame_cnt, 2);
      chk("es_fv", frame_valid, 0);
      send(8'h66, 1'b0, 1'b1);
      chk("es_err_drop", sync_err, 0);
      send(8'h77, 1'b0, 1'b1);
      send(8'h88, 1'b0, 1'b1);
      chk("es_fv_done", frame_valid, 1);
      chk("es_O0", O0, 8'h55);
      chk("es_O1", O1, 8'h66);
      chk("es_O3", O3, 8'h88);
      chk("es_cnt_done", frame_cnt, 3);

      // Missing sync on slot 0
      send(8'h99, 1'b0, 1'b1);
      chk("ms_err", sync_err, 1);
      chk("ms_locked", locked, 0);
      chk("ms_O0", O0, 8'h55);
      chk("ms_slot", slot, 0);

      // Partial frame abandoned by early sync
      send(8'hC1, 1'b1, 1'b1);
      send(8'hC2, 1'b0, 1'b1);
      send(8'hD1, 1'b1, 1'b1);
      chk("pf_err", sync_err, 1);
`ifdef TDM_DEMUX_SHADOW_EN
      chk("pf_O0", O0, 8'h55);
      chk("pf_O1", O1, 8'h66);
`else
      chk("pf_O0", O0, 8'hD1);
      chk("pf_O1", O1, 8'hC2);
`endif
      send(8'hD2, 1'b0, 1'b1);
      send(8'hD3, 1'b0, 1'b1);
      send(8'hD4, 1'b0, 1'b1);
      chk("pf_fv", frame_valid, 1);
      chk("pf_O0_done", O0, 8'hD1);
      chk("pf_O1_done", O1, 8'hD2);
      chk("pf_cnt", frame_cnt, 4);

      // 13 more good frames: 17 total wraps a 4-bit counter to 1
      for (int f = 0; f < 13; f++) begin
         send(8'(f),        1'b1, 1'b1);
         send(8'(f + 8'h40), 1'b0, 1'b1);
         send(8'(f + 8'h80), 1'b0, 1'b1);
         send(8'(f + 8'hC0), 1'b0, 1'b1);
      end
      chk("wrap_cnt", frame_cnt, 1);
      chk("wrap_O3", O3, 8'hCC);

      // Reset mid-frame clears outputs before the next edge
      send(8'hE1, 1'b1, 1'b1);
      send(8'hE2, 1'b0, 1'b1);
      @(negedge clk);
      din_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("ar_O0", O0, 0);
      chk("ar_O1", O1, 0);
      chk("ar_locked", locked, 0);
      chk("ar_slot", slot, 0);
      chk("ar_cnt", frame_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
